// File: rtl/hazard_pkg.sv
// Shared select codes, pipeline slot layout and producer test for the hazard/forwarding unit.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package hazard_pkg;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_ALT   = 2'b11;

    localparam int SLOT_RD_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } slot_t;

    // A slot produces r only when it will really write r; r0 is hardwired zero.
    function automatic logic produces(slot_t s, logic [SLOT_RD_W-1:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One pipeline tracking slot: captures d each cycle, or a bubble when bubble=1.
// Latency: 1 cycle.
// Backpressure: none; always advances, async reset clears to an empty slot.
module hazard_slot_reg
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    // Advance the slot, inserting an empty entry when asked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (bubble)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding select generation; HAZARD_FWD_FORWARD_EN enables forwarding.
// Latency: selects registered with the instruction into EX (1 cycle); stall is combinational.
// Backpressure: stall holds PC and IF/ID; a bubble enters EX on stall or flush.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = SLOT_RD_W  // must match the slot rd width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_use_imm,
    input  logic                  id_use_pc,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall
);

    slot_t      id_slot, ex_q, mem_q, wb_q;
    logic       load_ex;
    logic       use_rs, use_rt;
    logic       rs_ex, rs_mem, rt_ex, rt_mem;
    logic       hazard;
    logic [1:0] sel_a_nxt, sel_b_nxt;
    logic       slot_unused;

    // Only part of the oldest slots feeds the decision logic in each build.
    assign slot_unused = ^{wb_q, mem_q.mem_read};

    // Attributes of the ID instruction as they would enter EX.
    always_comb begin
        id_slot           = '0;
        id_slot.valid     = 1'b1;
        id_slot.rd        = id_rd;
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;
    end

    // Producer matches of the ID sources against the newer slots.
    always_comb begin
        use_rs = !id_use_pc;
        use_rt = !id_use_imm;
        rs_ex  = produces(ex_q,  id_rs);
        rs_mem = produces(mem_q, id_rs);
        rt_ex  = produces(ex_q,  id_rt);
        rt_mem = produces(mem_q, id_rt);
    end

`ifdef HAZARD_FWD_FORWARD_EN
    // Forwarding build: only a load in EX must wait; EX beats MEM on a double match.
    always_comb begin
        hazard    = ex_q.mem_read && ((use_rs && rs_ex) || (use_rt && rt_ex));
        sel_a_nxt = id_use_pc  ? SEL_ALT : rs_ex ? SEL_EXMEM : rs_mem ? SEL_MEMWB : SEL_RF;
        sel_b_nxt = id_use_imm ? SEL_ALT : rt_ex ? SEL_EXMEM : rt_mem ? SEL_MEMWB : SEL_RF;
    end
`else
    logic rs_wb, rt_wb;

    // Interlock-only build: wait until no in-flight slot still owes a used source.
    always_comb begin
        rs_wb     = produces(wb_q, id_rs);
        rt_wb     = produces(wb_q, id_rt);
        hazard    = (use_rs && (rs_ex || rs_mem || rs_wb)) ||
                    (use_rt && (rt_ex || rt_mem || rt_wb));
        sel_a_nxt = id_use_pc  ? SEL_ALT : SEL_RF;
        sel_b_nxt = id_use_imm ? SEL_ALT : SEL_RF;
    end
`endif

    // Flush outranks stall; reset forces stall low without waiting for a clock.
    always_comb begin
        stall   = !rst && id_valid && !flush && hazard;
        load_ex = id_valid && !stall && !flush;
    end

    hazard_slot_reg u_ex  (.clk(clk), .rst(rst), .bubble(!load_ex), .d(id_slot), .q(ex_q));
    hazard_slot_reg u_mem (.clk(clk), .rst(rst), .bubble(1'b0),     .d(ex_q),    .q(mem_q));
    hazard_slot_reg u_wb  (.clk(clk), .rst(rst), .bubble(1'b0),     .d(mem_q),   .q(wb_q));

    // Selects travel into EX with their instruction; a bubble carries register-file selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else if (load_ex) begin
            fwd_a_sel <= sel_a_nxt;
            fwd_b_sel <= sel_b_nxt;
        end else begin
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end
    end

endmodule
